// File: rtl/port_pmux_pkg.sv
// port_pmux_pkg: shared constants and types for the port A pin multiplexer.
//   - register word offsets (per_addr[4:2])
//   - FUNC field encodings, bus FSM states
//   - pin_drive(): per-pin pad drive selection from the FUNC field
package port_pmux_pkg;

   localparam int CHIP_PORT_A_WIDTH = 16;

   localparam logic [2:0] REG_FUNC    = 3'd0;
   localparam logic [2:0] REG_DIR     = 3'd1;
   localparam logic [2:0] REG_DOUT    = 3'd2;
   localparam logic [2:0] REG_DIN     = 3'd3;
   localparam logic [2:0] REG_RISE_EN = 3'd4;
   localparam logic [2:0] REG_FALL_EN = 3'd5;
   localparam logic [2:0] REG_STATUS  = 3'd6;
   localparam logic [2:0] REG_IRQ_EN  = 3'd7;

   typedef enum logic [1:0] {
      FUNC_GPIO = 2'd0,
      FUNC_AF1  = 2'd1,
      FUNC_AF2  = 2'd2,
      FUNC_OFF  = 2'd3
   } func_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RD   = 1'b1
   } bus_st_e;

   typedef struct packed {
      logic dout;
      logic oe;
      logic ie;
   } pad_drv_t;

   function automatic pad_drv_t pin_drive(input func_e f,
                                          input logic  g_dout, input logic g_oe,
                                          input logic  a1_dout, input logic a1_oe,
                                          input logic  a2_dout, input logic a2_oe);
      pad_drv_t d;
      d = '{dout: 1'b0, oe: 1'b0, ie: 1'b1};
      case (f)
         FUNC_GPIO: begin d.dout = g_dout;  d.oe = g_oe;  end
         FUNC_AF1:  begin d.dout = a1_dout; d.oe = a1_oe; end
         FUNC_AF2:  begin d.dout = a2_dout; d.oe = a2_oe; end
         default:   d.ie = 1'b0;   // off: pad fully disconnected
      endcase
      return d;
   endfunction

endpackage

// File: rtl/port_pmux_pin_sync.sv
// pmux_pin_sync: single-pin input synchronizer with edge history.
//   din  : pad input (already forced to 0 when the pin is off)
//   sync : synchronized level (s2)
//   rise : s2 & ~s3, fall : ~s2 & s3
module pmux_pin_sync (
   input  logic clk_in,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/port_pmux.sv
// port_pmux: port A pin multiplexer and GPIO controller.
//   per_*            : simple register bus; writes take 1 cycle, reads 2
//   af1_*, af2_*     : alternate-function drive/enable, passed through per pin
//   pmux_af_din      : synchronized pin input to the alternate functions
//   pad_pmux_din     : raw pad input
//   pmux_pad_*       : pad ring drive (dout/oe/ie)
//   irq              : level interrupt, |(STATUS & IRQ_EN)
module port_pmux
   import port_pmux_pkg::*;
#(
   parameter int WIDTH = CHIP_PORT_A_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             per_sel,
   input  logic             per_we,
   input  logic [4:0]       per_addr,
   input  logic [31:0]      per_wdata,
   output logic [31:0]      per_rdata,
   output logic             per_ready,
   input  logic [WIDTH-1:0] af1_dout,
   input  logic [WIDTH-1:0] af1_oe,
   input  logic [WIDTH-1:0] af2_dout,
   input  logic [WIDTH-1:0] af2_oe,
   output logic [WIDTH-1:0] pmux_af_din,
   input  logic [WIDTH-1:0] pad_pmux_din,
   output logic [WIDTH-1:0] pmux_pad_dout,
   output logic [WIDTH-1:0] pmux_pad_oe,
   output logic [WIDTH-1:0] pmux_pad_ie,
   output logic             irq
);

   logic [2*WIDTH-1:0] func_q;
   logic [WIDTH-1:0]   dir_q, dout_q, rise_en_q, fall_en_q, status_q, irq_en_q;
   logic [WIDTH-1:0]   sync_in, din_s, rise_s, fall_s, evt, w1c;
   logic [1:0]         arm_q;
   bus_st_e            state_q;
   logic [31:0]        rdata_q, rd_mux;
   logic [2:0]         reg_sel;
   logic               wr_en, rd_en;
   logic               unused_bits;

   assign reg_sel     = per_addr[4:2];
   assign wr_en       = (state_q == ST_IDLE) && per_sel && per_we;
   assign rd_en       = (state_q == ST_IDLE) && per_sel && !per_we;
   assign unused_bits = ^{per_addr[1:0], per_wdata};

   // Per-pin pad drive and synchronizer
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      pad_drv_t drv;
      assign drv = pin_drive(func_e'(func_q[2*i +: 2]), dout_q[i], dir_q[i],
                             af1_dout[i], af1_oe[i], af2_dout[i], af2_oe[i]);
      assign pmux_pad_dout[i] = drv.dout;
      assign pmux_pad_oe[i]   = drv.oe;
      assign pmux_pad_ie[i]   = drv.ie;
      // An off pin feeds 0, so switching a high pin off looks like a fall.
      assign sync_in[i]       = pad_pmux_din[i] & drv.ie;

      pmux_pin_sync u_sync (
         .clk_in (clk_in),
         .rst_n  (rst_n),
         .din    (sync_in[i]),
         .sync   (din_s[i]),
         .rise   (rise_s[i]),
         .fall   (fall_s[i])
      );
   end

   assign pmux_af_din = din_s;

   // Edges only count once the arm counter has saturated, so the
   // synchronizer filling with the reset-time pin state is never reported.
   assign evt = (arm_q == 2'd3) ? ((rise_s & rise_en_q) | (fall_s & fall_en_q)) : '0;
   assign w1c = (wr_en && reg_sel == REG_STATUS) ? per_wdata[WIDTH-1:0] : '0;

   assign irq = |(status_q & irq_en_q);

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_FUNC:    rd_mux[2*WIDTH-1:0] = func_q;
         REG_DIR:     rd_mux[WIDTH-1:0]   = dir_q;
         REG_DOUT:    rd_mux[WIDTH-1:0]   = dout_q;
         REG_DIN:     rd_mux[WIDTH-1:0]   = din_s;
         REG_RISE_EN: rd_mux[WIDTH-1:0]   = rise_en_q;
         REG_FALL_EN: rd_mux[WIDTH-1:0]   = fall_en_q;
         REG_STATUS:  rd_mux[WIDTH-1:0]   = status_q;
         default:     rd_mux[WIDTH-1:0]   = irq_en_q;
      endcase
   end

   // Register file
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         func_q    <= '0;
         dir_q     <= '0;
         dout_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         irq_en_q  <= '0;
         arm_q     <= 2'd0;
      end else begin
         if (arm_q != 2'd3)
            arm_q <= arm_q + 2'd1;
         if (wr_en) begin
            case (reg_sel)
               REG_FUNC:    func_q    <= per_wdata[2*WIDTH-1:0];
               REG_DIR:     dir_q     <= per_wdata[WIDTH-1:0];
               REG_DOUT:    dout_q    <= per_wdata[WIDTH-1:0];
               REG_RISE_EN: rise_en_q <= per_wdata[WIDTH-1:0];
               REG_FALL_EN: fall_en_q <= per_wdata[WIDTH-1:0];
               REG_IRQ_EN:  irq_en_q  <= per_wdata[WIDTH-1:0];
               default: ;
            endcase
         end
         // Set has priority over a simultaneous write-1-to-clear.
         status_q <= (status_q & ~w1c) | evt;
      end
   end

   // Bus FSM: reads capture into rdata_q and complete from RD
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (rd_en) begin
               rdata_q <= rd_mux;
               state_q <= ST_RD;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign per_ready = wr_en || (state_q == ST_RD);
   assign per_rdata = rdata_q;

endmodule

// File: tb/tb_port_pmux.sv
// tb_port_pmux: directed plus randomized bench for port_pmux against a
// behavioural model built from the register/pad rules.
module tb_port_pmux;

   localparam int W = 16;
   localparam logic [4:0] A_FUNC = 5'd0,  A_DIR  = 5'd4,  A_DOUT = 5'd8,  A_DIN   = 5'd12;
   localparam logic [4:0] A_RISE = 5'd16, A_FALL = 5'd20, A_STAT = 5'd24, A_IRQEN = 5'd28;

   logic          clk_in = 1'b0;
   logic          rst_n = 1'b0;
   logic          per_sel = 1'b0, per_we = 1'b0;
   logic [4:0]    per_addr = '0;
   logic [31:0]   per_wdata = '0;
   logic [31:0]   per_rdata;
   logic          per_ready;
   logic [W-1:0]  af1_dout = '0, af1_oe = '0, af2_dout = '0, af2_oe = '0;
   logic [W-1:0]  pmux_af_din;
   logic [W-1:0]  pad_pmux_din = '0;
   logic [W-1:0]  pmux_pad_dout, pmux_pad_oe, pmux_pad_ie;
   logic          irq;

   port_pmux #(.WIDTH(W)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .per_sel(per_sel), .per_we(per_we),
      .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata),
      .per_ready(per_ready), .af1_dout(af1_dout), .af1_oe(af1_oe),
      .af2_dout(af2_dout), .af2_oe(af2_oe), .pmux_af_din(pmux_af_din),
      .pad_pmux_din(pad_pmux_din), .pmux_pad_dout(pmux_pad_dout),
      .pmux_pad_oe(pmux_pad_oe), .pmux_pad_ie(pmux_pad_ie), .irq(irq)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int failures = 0;

   // Behavioural model
   logic [31:0]  m_func, m_cap;
   logic [W-1:0] m_dir, m_dout, m_rise, m_fall, m_stat, m_irqen;
   logic [W-1:0] smp[$];   // pad samples taken at past edges, newest first
   int           m_edges;  // edges since reset release
   bit           m_rd;     // a read is in its data cycle

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_func = '0; m_dir = '0; m_dout = '0; m_rise = '0; m_fall = '0;
      m_stat = '0; m_irqen = '0; m_cap = '0; m_rd = 1'b0; m_edges = 0;
      smp.delete();
      for (int i = 0; i < 3; i++) smp.push_back('0);
   endfunction

   // kind: 0 = dout, 1 = oe, 2 = ie
   function automatic logic [W-1:0] exp_pad(input int kind);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (int'(m_func[2*i +: 2]))
            0: r[i] = (kind == 0) ? m_dout[i]   : (kind == 1) ? m_dir[i]  : 1'b1;
            1: r[i] = (kind == 0) ? af1_dout[i] : (kind == 1) ? af1_oe[i] : 1'b1;
            2: r[i] = (kind == 0) ? af2_dout[i] : (kind == 1) ? af2_oe[i] : 1'b1;
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [31:0] rd_model(input logic [4:0] a);
      case (int'(a[4:2]))
         0: return m_func;
         1: return {16'h0, m_dir};
         2: return {16'h0, m_dout};
         3: return {16'h0, smp[1]};
         4: return {16'h0, m_rise};
         5: return {16'h0, m_fall};
         6: return {16'h0, m_stat};
         default: return {16'h0, m_irqen};
      endcase
   endfunction

   // Advance the model by one clock edge, using inputs as they were at the edge.
   function automatic void model_step();
      logic [W-1:0] ev, eff, w1c;
      eff = pad_pmux_din & exp_pad(2);
      ev  = ((smp[1] & ~smp[2]) & m_rise) | ((~smp[1] & smp[2]) & m_fall);
      if (m_edges < 3) ev = '0;
      w1c = '0;
      if (m_rd) m_rd = 1'b0;
      else if (per_sel && !per_we) begin
         m_cap = rd_model(per_addr);
         m_rd  = 1'b1;
      end else if (per_sel && per_we) begin
         case (int'(per_addr[4:2]))
            0: m_func  = per_wdata;
            1: m_dir   = per_wdata[W-1:0];
            2: m_dout  = per_wdata[W-1:0];
            4: m_rise  = per_wdata[W-1:0];
            5: m_fall  = per_wdata[W-1:0];
            6: w1c     = per_wdata[W-1:0];
            7: m_irqen = per_wdata[W-1:0];
            default: ;
         endcase
      end
      m_stat = (m_stat & ~w1c) | ev;
      smp.push_front(eff);
      void'(smp.pop_back());
      m_edges++;
   endfunction

   task automatic cyc();
      @(posedge clk_in);
      if (rst_n) model_step();
      else       model_reset();
      @(negedge clk_in);
   endtask

   task automatic check_all();
      chk("pad_dout", {16'h0, pmux_pad_dout}, {16'h0, exp_pad(0)});
      chk("pad_oe",   {16'h0, pmux_pad_oe},   {16'h0, exp_pad(1)});
      chk("pad_ie",   {16'h0, pmux_pad_ie},   {16'h0, exp_pad(2)});
      chk("af_din",   {16'h0, pmux_af_din},   {16'h0, smp[1]});
      chk("irq",      {31'h0, irq},           {31'h0, |(m_stat & m_irqen)});
      chk("ready",    {31'h0, per_ready},     {31'h0, m_rd | (per_sel & per_we)});
      if (m_rd) chk("rdata", per_rdata, m_cap);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      per_sel = 1'b1; per_we = 1'b1; per_addr = a; per_wdata = d;
      #1;
      chk("wr_ready", {31'h0, per_ready}, 32'h1);
      cyc();
      per_sel = 1'b0; per_we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      per_sel = 1'b1; per_we = 1'b0; per_addr = a;
      #1;
      chk("rd_ready_first", {31'h0, per_ready}, 32'h0);
      cyc();
      chk("rd_ready_second", {31'h0, per_ready}, 32'h1);
      chk("rd_data", per_rdata, m_cap);
      d = per_rdata;
      cyc();
      per_sel = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int op;
      model_reset();

      // Reset with pads held high
      pad_pmux_din = 16'hFFFF;
      repeat (3) cyc();
      chk("rst_oe",    {16'h0, pmux_pad_oe},   32'h0);
      chk("rst_ie",    {16'h0, pmux_pad_ie},   32'hFFFF);
      chk("rst_dout",  {16'h0, pmux_pad_dout}, 32'h0);
      chk("rst_ready", {31'h0, per_ready},     32'h0);
      chk("rst_rdata", per_rdata,              32'h0);
      chk("rst_irq",   {31'h0, irq},           32'h0);
      chk("rst_afdin", {16'h0, pmux_af_din},   32'h0);
      rst_n = 1'b1;
      wr(A_RISE, 32'hFFFF);
      repeat (5) cyc();
      rd(A_STAT, d);
      chk("arm_status", d, 32'h0);

      // GPIO output
      pad_pmux_din = 16'h0;
      wr(A_RISE, 32'h0);
      wr(A_DIR, 32'h00F0);
      wr(A_DOUT, 32'h00A0);
      #1;
      chk("gpio_oe",   {16'h0, pmux_pad_oe},   32'h00F0);
      chk("gpio_dout", {16'h0, pmux_pad_dout}, 32'h00A0);

      // Alternate functions on pins 0 and 1
      af1_dout = 16'h0001; af1_oe = 16'h0001; af2_dout = 16'h0000; af2_oe = 16'h0002;
      wr(A_FUNC, 32'h0000_0009);
      #1;
      chk("af_oe",   {16'h0, pmux_pad_oe},   32'h00F3);
      chk("af_dout", {16'h0, pmux_pad_dout}, 32'h00A1);
      check_all();

      // Rising edge interrupt on pin 2
      wr(A_STAT, 32'hFFFF);
      wr(A_RISE, 32'h0004);
      wr(A_IRQEN, 32'h0004);
      repeat (4) cyc();
      pad_pmux_din = 16'h0004;
      cyc(); cyc();
      chk("edge_din", {16'h0, pmux_af_din}, 32'h0004);
      chk("edge_irq_early", {31'h0, irq}, 32'h0);
      cyc();
      chk("edge_irq", {31'h0, irq}, 32'h1);
      rd(A_STAT, d);
      chk("edge_status", d, 32'h0004);
      wr(A_STAT, 32'h0004);
      #1;
      chk("w1c_irq", {31'h0, irq}, 32'h0);

      // DIN is read-only
      wr(A_DIN, 32'hFFFF);
      rd(A_DIN, d);
      chk("din_ro", d, 32'h0004);

      // Collision: W1C on the same edge as a pin 3 fall event
      wr(A_FALL, 32'h0008);
      pad_pmux_din = 16'h000C;
      repeat (4) cyc();
      wr(A_STAT, 32'hFFFF);
      pad_pmux_din = 16'h0004;
      cyc(); cyc();
      wr(A_STAT, 32'h0008);
      rd(A_STAT, d);
      chk("collision", d & 32'h8, 32'h8);
      check_all();

      // Reset during the read data cycle
      per_sel = 1'b1; per_we = 1'b0; per_addr = A_DIN;
      #1;
      cyc();
      chk("abort_rd_ready", {31'h0, per_ready}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", {31'h0, per_ready}, 32'h0);
      model_reset();
      per_sel = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1;
      check_all();

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         pad_pmux_din = 16'($urandom);
         af1_dout = 16'($urandom); af1_oe = 16'($urandom);
         af2_dout = 16'($urandom); af2_oe = 16'($urandom);
         op = int'($urandom_range(0, 9));
         if (op < 4) begin
            per_sel = 1'b1; per_we = 1'b1;
            per_addr = 5'($urandom_range(0, 7) << 2); per_wdata = $urandom;
            #1; check_all(); cyc();
            per_sel = 1'b0; per_we = 1'b0;
         end else if (op < 7) begin
            per_sel = 1'b1; per_we = 1'b0;
            per_addr = 5'($urandom_range(0, 7) << 2);
            #1; check_all(); cyc();
            #1; check_all(); cyc();
            per_sel = 1'b0;
         end else begin
            #1; check_all(); cyc();
         end
      end
      #1; check_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
